// File: rtl/snake_pkg.sv
// snake_pkg: encodings and helpers shared by the snake movement scheduler.
//   - game_status_e : RESTART / START / PLAY / DIE, as driven by the game-state controller
//   - dir_e         : UP / DOWN / LEFT / RIGHT move directions
//   - reverse_dir() : the opposite direction (flip of bit 0)
//   - move_period() : ticks per move for a given level, clamped to a floor
package snake_pkg;

  typedef enum logic [1:0] {
    GS_RESTART = 2'b00,
    GS_START   = 2'b01,
    GS_PLAY    = 2'b10,
    GS_DIE     = 2'b11
  } game_status_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam logic [1:0] DIR_REVERSE_MASK = 2'b01;

  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ DIR_REVERSE_MASK;
  endfunction

  // max(base - lvl*step, min_p) in 32-bit unsigned arithmetic; a reduction
  // larger than base clamps straight to the floor instead of wrapping.
  // A zero result is bumped to 1 so the terminal count period-1 never wraps.
  function automatic logic [31:0] move_period(input logic [31:0] lvl,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] min_p);
    logic [31:0] red;
    logic [31:0] p;
    red = lvl * step;
    if (red >= base) begin
      p = min_p;
    end else begin
      p = base - red;
      if (p < min_p) p = min_p;
    end
    if (p == 32'd0) p = 32'd1;
    return p;
  endfunction

endpackage

// File: rtl/snake_turn_queue.sv
// snake_turn_queue: buffers filtered turn requests for the move scheduler.
// Build option: SNAKE_TURN_QUEUE_EN
//   defined     : 2-entry FIFO; candidates are filtered against the tail
//                 (or the current direction when empty); pushes into a full
//                 queue are dropped.
//   not defined : single pending-turn register, overwritten by each accepted
//                 key; candidates are filtered against the current direction.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous clear (game restart)
//   accept_en   : keys may be accepted this cycle
//   key_valid   : an arbitrated key is present; key_dir is its direction
//   pop         : a move is being issued this cycle
//   cur_dir     : direction of the current/last move
//   next_dir    : direction the issued move takes if pop is asserted now
module snake_turn_queue
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       accept_en,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  input  logic       pop,
  input  logic [1:0] cur_dir,
  output logic [1:0] next_dir
);

  logic [1:0] ref_dir;
  logic       push;

`ifdef SNAKE_TURN_QUEUE_EN
  logic [1:0] q0_reg, q1_reg;
  logic [1:0] cnt_reg;
  logic [1:0] q0_post, q1_post, cnt_post;

  always_comb begin
    next_dir = (cnt_reg != 2'd0) ? q0_reg : cur_dir;
    q0_post  = q0_reg;
    q1_post  = q1_reg;
    cnt_post = cnt_reg;
    // The pop is applied before the filter looks at the tail.
    if (pop && cnt_reg != 2'd0) begin
      q0_post  = q1_reg;
      cnt_post = cnt_reg - 2'd1;
    end
    case (cnt_post)
      2'd1:    ref_dir = q0_post;
      2'd2:    ref_dir = q1_post;
      default: ref_dir = pop ? next_dir : cur_dir;
    endcase
    push = accept_en && key_valid && (key_dir != ref_dir) &&
           (key_dir != reverse_dir(ref_dir)) && (cnt_post != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0_reg  <= DIR_UP;
      q1_reg  <= DIR_UP;
      cnt_reg <= 2'd0;
    end else if (clear) begin
      q0_reg  <= DIR_UP;
      q1_reg  <= DIR_UP;
      cnt_reg <= 2'd0;
    end else begin
      q0_reg  <= q0_post;
      q1_reg  <= q1_post;
      cnt_reg <= cnt_post;
      if (push) begin
        if (cnt_post == 2'd0) q0_reg <= key_dir;
        else                  q1_reg <= key_dir;
        cnt_reg <= cnt_post + 2'd1;
      end
    end
  end
`else
  logic       pend_valid_reg;
  logic [1:0] pend_dir_reg;

  always_comb begin
    next_dir = pend_valid_reg ? pend_dir_reg : cur_dir;
    ref_dir  = pop ? next_dir : cur_dir;
    push     = accept_en && key_valid && (key_dir != ref_dir) &&
               (key_dir != reverse_dir(ref_dir));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_reg <= 1'b0;
      pend_dir_reg   <= DIR_UP;
    end else if (clear) begin
      pend_valid_reg <= 1'b0;
      pend_dir_reg   <= DIR_UP;
    end else if (push) begin
      pend_valid_reg <= 1'b1;
      pend_dir_reg   <= key_dir;
    end else if (pop) begin
      pend_valid_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/snake_move_sched.sv
// snake_move_sched: paces snake moves with a level-dependent tick and hands
// one move at a time to the body datapath over a req/ack handshake.
// Build option: SNAKE_TURN_QUEUE_EN selects the 2-entry turn queue inside
// snake_turn_queue; otherwise a single pending-turn register is used.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   game_status[1:0]        : 00 RESTART, 01 START, 10 PLAY, 11 DIE
//   key1..key4_press        : up/down/left/right pulses (key1 has priority)
//   level_up                : food eaten pulse, counted in PLAY only
//   move_ack                : datapath consumed the pending move
//   move_req                : a move is pending, held until acked
//   dir[1:0]                : direction of the current or last move
//   level[LEVEL_W-1:0]      : speed level, saturating
module snake_move_sched
  import snake_pkg::*;
#(
  parameter int unsigned TICK_BASE = 12_500_000,
  parameter int unsigned TICK_STEP = 1_000_000,
  parameter int unsigned TICK_MIN  = 3_000_000,
  parameter int          LEVEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         game_status,
  input  logic               key1_press,
  input  logic               key2_press,
  input  logic               key3_press,
  input  logic               key4_press,
  input  logic               level_up,
  input  logic               move_ack,
  output logic               move_req,
  output logic [1:0]         dir,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [31:0] PERIOD_L0 = move_period(32'd0, TICK_BASE, TICK_STEP, TICK_MIN);

  game_status_e       gs;
  logic [31:0]        period_calc;
  logic [31:0]        period_reg;
  logic [31:0]        cnt_reg;
  logic               move_req_reg;
  logic [1:0]         dir_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic               terminal;
  logic               issue;
  logic               key_valid;
  logic [1:0]         key_dir;
  logic [1:0]         next_dir;

  assign gs          = game_status_e'(game_status);
  assign period_calc = move_period(32'(level_reg), TICK_BASE, TICK_STEP, TICK_MIN);
  // period_reg only changes when the counter reloads to 0, so a level change
  // never cuts the running count short.
  assign terminal    = (cnt_reg == period_reg - 32'd1);
  assign issue       = (gs == GS_PLAY) && terminal && !move_req_reg;

  always_comb begin
    key_valid = 1'b0;
    key_dir   = DIR_UP;
    if (key1_press) begin
      key_valid = 1'b1;
      key_dir   = DIR_UP;
    end else if (key2_press) begin
      key_valid = 1'b1;
      key_dir   = DIR_DOWN;
    end else if (key3_press) begin
      key_valid = 1'b1;
      key_dir   = DIR_LEFT;
    end else if (key4_press) begin
      key_valid = 1'b1;
      key_dir   = DIR_RIGHT;
    end
  end

  snake_turn_queue u_turn_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (gs == GS_RESTART),
    .accept_en ((gs == GS_START) || (gs == GS_PLAY)),
    .key_valid (key_valid),
    .key_dir   (key_dir),
    .pop       (issue),
    .cur_dir   (dir_reg),
    .next_dir  (next_dir)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= 32'd0;
      period_reg   <= PERIOD_L0;
      move_req_reg <= 1'b0;
      dir_reg      <= DIR_RIGHT;
      level_reg    <= '0;
    end else begin
      case (gs)
        GS_RESTART: begin
          cnt_reg      <= 32'd0;
          period_reg   <= PERIOD_L0;
          move_req_reg <= 1'b0;
          dir_reg      <= DIR_RIGHT;
          level_reg    <= '0;
        end
        GS_START: begin
          cnt_reg      <= 32'd0;
          period_reg   <= period_calc;
          move_req_reg <= 1'b0;
        end
        GS_PLAY: begin
          if (move_req_reg && move_ack) move_req_reg <= 1'b0;
          if (issue) begin
            move_req_reg <= 1'b1;
            dir_reg      <= next_dir;
            cnt_reg      <= 32'd0;
            period_reg   <= period_calc;
          end else if (!terminal) begin
            cnt_reg <= cnt_reg + 32'd1;
          end
          // At terminal with a move still outstanding the count holds, so the
          // tick is delivered as soon as the ack clears move_req.
          if (level_up && level_reg != LEVEL_MAX) level_reg <= level_reg + 1'b1;
        end
        default: begin
          // DIE: counter, queue, dir and level frozen; outstanding move dropped.
          move_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign move_req = move_req_reg;
  assign dir      = dir_reg;
  assign level    = level_reg;

endmodule

// File: tb/tb_snake_move_sched.sv
// tb_snake_move_sched: directed bench for snake_move_sched.
// dut_a (period 10 at level 0) exercises moves, turn filtering, backpressure,
// death and reset; dut_b (base 12, step 1, floor 5) exercises speed scaling.
// Expected move directions are pushed into a scoreboard queue when keys are
// driven and popped when dut_a raises move_req.
module tb_snake_move_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] game_status;
  logic       k1, k2, k3, k4;
  logic       lvl_up_a, lvl_up_b;
  logic       ack_a;
  logic       req_a, req_b;
  logic [1:0] dir_a, dir_b;
  logic [3:0] level_a, level_b;

  int         n_checks;
  int         n_fail;
  int         cyc;
  int         last_rise;
  logic [1:0] sb[$];
  logic [1:0] cur_dir;

  snake_move_sched #(.TICK_BASE(10), .TICK_STEP(1), .TICK_MIN(5), .LEVEL_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .game_status(game_status),
    .key1_press(k1), .key2_press(k2), .key3_press(k3), .key4_press(k4),
    .level_up(lvl_up_a), .move_ack(ack_a),
    .move_req(req_a), .dir(dir_a), .level(level_a)
  );

  snake_move_sched #(.TICK_BASE(12), .TICK_STEP(1), .TICK_MIN(5), .LEVEL_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .game_status(game_status),
    .key1_press(1'b0), .key2_press(1'b0), .key3_press(1'b0), .key4_press(1'b0),
    .level_up(lvl_up_b), .move_ack(1'b1),
    .move_req(req_b), .dir(dir_b), .level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for the current request (if any) to drop, then for the next rise on
  // dut_a; compare interval (when exp_int > 0) and the scoreboard direction.
  task automatic next_move_a(input int exp_int);
    int         c;
    int         iv;
    logic [1:0] e;
    c = 0;
    while (req_a && c < 200) begin tick(); c++; end
    while (!req_a && c < 200) begin tick(); c++; end
    check("move_req_a_seen", {31'd0, req_a}, 32'd1);
    iv = cyc - last_rise;
    last_rise = cyc;
    if (exp_int > 0) check("move_interval", iv, exp_int);
    // With nothing scheduled, any observed direction is a mismatch.
    if (sb.size() != 0) e = sb.pop_front();
    else                e = ~dir_a;
    check("move_dir", {30'd0, dir_a}, {30'd0, e});
    $display("move cycle=%0d dir=%0d expected=%0d interval=%0d", cyc, dir_a, e, iv);
  endtask

  task automatic wait_rise_b(output int at);
    int c;
    c = 0;
    while (req_b && c < 100) begin tick(); c++; end
    while (!req_b && c < 100) begin tick(); c++; end
    check("move_req_b_seen", {31'd0, req_b}, 32'd1);
    at = cyc;
    $display("move_b cycle=%0d level=%0d", cyc, level_b);
  endtask

  initial begin
    int bad;
    int t0, t1, t2, t3;
    n_checks = 0; n_fail = 0; cyc = 0; last_rise = 0;
    rst_n = 1'b0; game_status = 2'b00;
    k1 = 0; k2 = 0; k3 = 0; k4 = 0;
    lvl_up_a = 0; lvl_up_b = 0; ack_a = 1'b1;
    cur_dir = 2'b11;

    // Reset state
    repeat (3) tick();
    check("rst_move_req", {31'd0, req_a}, 32'd0);
    check("rst_dir", {30'd0, dir_a}, 32'd3);
    check("rst_level", {28'd0, level_a}, 32'd0);
    check("rst_level_b", {28'd0, level_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Initial moves, no keys: dir stays right, one request every 10 cycles
    game_status = 2'b10;
    last_rise = cyc;
    sb.push_back(2'b11); next_move_a(10);
    sb.push_back(2'b11); next_move_a(10);

    // Reversal then duplicate of the current direction: both discarded
    k3 = 1; tick(); k3 = 0;
    k4 = 1; tick(); k4 = 0;
    sb.push_back(2'b11); next_move_a(10);

    // Queue fill: up, left, down in consecutive cycles
    k1 = 1; tick(); k1 = 0;
    k3 = 1; tick(); k3 = 0;
    k2 = 1; tick(); k2 = 0;
`ifdef SNAKE_TURN_QUEUE_EN
    sb.push_back(2'b00); sb.push_back(2'b10); cur_dir = 2'b10;
`else
    // left is the reverse of right; down overwrites the pending up
    sb.push_back(2'b01); sb.push_back(2'b01); cur_dir = 2'b01;
`endif
    next_move_a(10);
    next_move_a(10);

    // Backpressure: ack withheld for 25 cycles after the request rises
    tick();
    ack_a = 1'b0;
    sb.push_back(cur_dir); next_move_a(10);
    bad = 0;
    repeat (25) begin
      tick();
      if (req_a !== 1'b1 || dir_a !== cur_dir) bad++;
    end
    check("backpressure_hold", bad, 0);
    ack_a = 1'b1;
    sb.push_back(cur_dir); next_move_a(27);
    sb.push_back(cur_dir); next_move_a(10);

    // Speed scaling on dut_b
    wait_rise_b(t0);
    wait_rise_b(t1);
    check("period_level0_b", t1 - t0, 12);
    repeat (20) begin
      lvl_up_b = 1; tick(); lvl_up_b = 0; tick();
    end
    check("level_sat_b", {28'd0, level_b}, 32'd15);
    wait_rise_b(t2);
    wait_rise_b(t3);
    check("period_min_b", t3 - t2, 5);

    // Death while a move is outstanding
    ack_a = 1'b0;
    sb.push_back(cur_dir); next_move_a(-1);
    game_status = 2'b11;
    tick();
    check("die_req_clear", {31'd0, req_a}, 32'd0);
    if (cur_dir[1] == 1'b0) k3 = 1; else k1 = 1;
    tick(); k1 = 0; k3 = 0;
    lvl_up_a = 1; tick(); lvl_up_a = 0;
    bad = 0;
    repeat (15) begin
      tick();
      if (req_a !== 1'b0) bad++;
    end
    check("die_no_req", bad, 0);
    check("die_level_frozen", {28'd0, level_a}, 32'd0);
    check("die_dir_frozen", {30'd0, dir_a}, {30'd0, cur_dir});
    // Back to play: the counter resumes from its frozen value and the key
    // pressed during DIE must not appear.
    game_status = 2'b10;
    ack_a = 1'b1;
    last_rise = cyc;
    sb.push_back(cur_dir); next_move_a(10);
    repeat (3) begin
      lvl_up_a = 1; tick(); lvl_up_a = 0; tick();
    end
    check("level_a_count", {28'd0, level_a}, 32'd3);

    // RESTART restores reset values
    game_status = 2'b00;
    tick();
    check("restart_dir", {30'd0, dir_a}, 32'd3);
    check("restart_level", {28'd0, level_a}, 32'd0);
    check("restart_level_b", {28'd0, level_b}, 32'd0);
    check("restart_req", {31'd0, req_a}, 32'd0);

    // START preloads the opening direction without issuing moves
    game_status = 2'b01;
    tick();
    k1 = 1; tick(); k1 = 0;
    bad = 0;
    repeat (12) begin
      tick();
      if (req_a !== 1'b0) bad++;
    end
    check("start_no_req", bad, 0);
    game_status = 2'b10;
    ack_a = 1'b0;
    last_rise = cyc;
    sb.push_back(2'b00); next_move_a(10);

    // Asynchronous reset in the middle of a handshake
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, req_a}, 32'd0);
    check("async_rst_dir", {30'd0, dir_a}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
